// File: rtl/wb_arbiter_rr_pkg.sv
// Shared Wishbone constants, arbiter state encoding, request payload and slave address map.
package wb_arbiter_rr_pkg;

   localparam int unsigned WB_ADR_W = 32;
   localparam int unsigned WB_DAT_W = 32;
   localparam int unsigned WB_SEL_W = 4;

   localparam logic [WB_ADR_W-1:0] ADR_UART_CTRL = 32'h0000_0003;
   localparam logic [WB_ADR_W-1:0] ADR_BAUD      = 32'h0000_0004;
   localparam logic [WB_ADR_W-1:0] ADR_UART_STAT = 32'h0000_0005;
   localparam logic [WB_ADR_W-1:0] ADR_TX_BUF    = 32'h0000_0007;
   localparam logic [WB_ADR_W-1:0] ADR_CNT_CTRL  = 32'h0000_0008;
   localparam logic [WB_ADR_W-1:0] ADR_RESULT    = 32'h0000_0009;
   localparam logic [WB_ADR_W-1:0] ADR_INTERP    = 32'h0000_000A;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_TOUT  = 2'd2
   } arb_state_t;

   // Per-master request payload that is muxed onto the slave side.
   typedef struct packed {
      logic                we;
      logic                lock;
      logic [WB_SEL_W-1:0] sel;
      logic [WB_ADR_W-1:0] adr;
      logic [WB_DAT_W-1:0] dat;
   } wb_req_t;

   function automatic logic adr_mapped(input logic [WB_ADR_W-1:0] adr);
      return adr inside {ADR_UART_CTRL, ADR_BAUD, ADR_UART_STAT, ADR_TX_BUF,
                         ADR_CNT_CTRL, ADR_RESULT, ADR_INTERP};
   endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// Bundle of master-side and slave-side Wishbone signals around the arbiter.
interface wb_arbiter_rr_if
   import wb_arbiter_rr_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2
);
   logic [NUM_MASTERS-1:0]          m_cyc_i;
   logic [NUM_MASTERS-1:0]          m_stb_i;
   logic [NUM_MASTERS-1:0]          m_we_i;
   logic [NUM_MASTERS-1:0]          m_lock_i;
   logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i;
   logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i;
   logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i;
   logic [WB_DAT_W-1:0]             m_dat_o;
   logic [NUM_MASTERS-1:0]          m_ack_o;
   logic [NUM_MASTERS-1:0]          m_err_o;
   logic [NUM_MASTERS-1:0]          m_rty_o;

   logic                s_cyc_o;
   logic                s_stb_o;
   logic                s_we_o;
   logic                s_lock_o;
   logic [WB_SEL_W-1:0] s_sel_o;
   logic [WB_ADR_W-1:0] s_adr_o;
   logic [WB_DAT_W-1:0] s_dat_o;
   logic [WB_DAT_W-1:0] s_dat_i;
   logic                s_ack_i;
   logic                s_err_i;
   logic                s_rty_i;

   logic [NUM_MASTERS-1:0] grant_o;
   logic                   timeout_o;

   // Arbiter view.
   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_lock_i, m_sel_i, m_adr_i, m_dat_i,
      input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
      output m_dat_o, m_ack_o, m_err_o, m_rty_o,
      output s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_sel_o, s_adr_o, s_dat_o,
      output grant_o, timeout_o
   );

   // Environment view: masters plus the shared slave.
   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_lock_i, m_sel_i, m_adr_i, m_dat_i,
      output s_dat_i, s_ack_i, s_err_i, s_rty_i,
      input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_sel_o, s_adr_o, s_dat_o,
      input  grant_o, timeout_o
   );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Round-robin priority selector: first requester after the last owner, wrapping.
module wb_arbiter_rr_pick #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W-1:0] cand;

   // Scan last+1 .. last+N so the previous owner has the lowest priority.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = IDX_W'((32'(last) + i) % N);
         if (!valid && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = cand;
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B4 classic arbiter with per-transfer timeout and lock support.
module wb_arbiter_rr
   import wb_arbiter_rr_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned TIMEOUT     = 1024,
   parameter int unsigned TO_W        = 16
) (
   input logic            clk_i,
   input logic            rst_i,
   wb_arbiter_rr_if.slave bus
);

   localparam int unsigned     IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   arb_state_t             state, state_nxt;
   logic [NUM_MASTERS-1:0] grant, grant_nxt;
   logic [IDX_W-1:0]       last, last_nxt;
   logic [TO_W-1:0]        cnt, cnt_nxt;

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;

   wb_req_t                req_a [NUM_MASTERS];
   wb_req_t                s_req;
   logic                   s_cyc, s_stb, tout;
   logic [NUM_MASTERS-1:0] ack, err, rty;

   for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
      assign req_a[k] = '{we:   bus.m_we_i[k],
                          lock: bus.m_lock_i[k],
                          sel:  bus.m_sel_i[k*WB_SEL_W +: WB_SEL_W],
                          adr:  bus.m_adr_i[k*WB_ADR_W +: WB_ADR_W],
                          dat:  bus.m_dat_i[k*WB_DAT_W +: WB_DAT_W]};
   end

   wb_arbiter_rr_pick #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (bus.m_cyc_i),
      .last  (last),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
         grant <= '0;
         last  <= IDX_W'(NUM_MASTERS - 1);
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // While owned, last always holds the index of the granted master.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      last_nxt  = last;
      cnt_nxt   = cnt;
      s_cyc     = 1'b0;
      s_stb     = 1'b0;
      s_req     = '0;
      ack       = '0;
      err       = '0;
      rty       = '0;
      tout      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (pick_valid) begin
               grant_nxt = pick_gnt;
               last_nxt  = pick_idx;
               state_nxt = ST_OWNED;
            end
         end
         ST_OWNED: begin
            s_cyc = bus.m_cyc_i[last];
            s_stb = bus.m_stb_i[last];
            s_req = req_a[last];
            if (s_stb) begin
               err[last] = bus.s_err_i;
               ack[last] = bus.s_ack_i & ~bus.s_err_i;
               rty[last] = bus.s_rty_i;
            end
            if (!(bus.m_cyc_i[last] || bus.m_lock_i[last])) begin
               state_nxt = ST_IDLE;
               grant_nxt = '0;
               cnt_nxt   = '0;
            end else if (bus.s_ack_i || bus.s_err_i || bus.s_rty_i) begin
               cnt_nxt = '0;
            end else if (s_stb) begin
               if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                  state_nxt = ST_TOUT;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + TO_W'(1);
               end
            end
         end
         ST_TOUT: begin
            // Slave is cut off for one cycle; the owner keeps the grant and sees err.
            s_req     = req_a[last];
            err[last] = 1'b1;
            tout      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_OWNED;
         end
         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   assign bus.s_cyc_o   = s_cyc;
   assign bus.s_stb_o   = s_stb;
   assign bus.s_we_o    = s_req.we;
   assign bus.s_lock_o  = s_req.lock;
   assign bus.s_sel_o   = s_req.sel;
   assign bus.s_adr_o   = s_req.adr;
   assign bus.s_dat_o   = s_req.dat;
   assign bus.m_dat_o   = bus.s_dat_i;
   assign bus.m_ack_o   = ack;
   assign bus.m_err_o   = err;
   assign bus.m_rty_o   = rty;
   assign bus.grant_o   = grant;
   assign bus.timeout_o = tout;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: two masters, TIMEOUT=16.
module tb_wb_arbiter_rr;
   import wb_arbiter_rr_pkg::*;

   localparam int unsigned NM = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   wb_arbiter_rr_if #(.NUM_MASTERS(NM)) bus ();

   wb_arbiter_rr #(
      .NUM_MASTERS (NM),
      .TIMEOUT     (16),
      .TO_W        (16)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic drive_m(input int k, input logic cyc, input logic stb, input logic we,
                          input logic lock, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
      bus.m_cyc_i[k]          = cyc;
      bus.m_stb_i[k]          = stb;
      bus.m_we_i[k]           = we;
      bus.m_lock_i[k]         = lock;
      bus.m_adr_i[k*32 +: 32] = adr;
      bus.m_dat_i[k*32 +: 32] = dat;
      bus.m_sel_i[k*4 +: 4]   = sel;
   endtask

   task automatic clear_all();
      bus.m_cyc_i  = '0;
      bus.m_stb_i  = '0;
      bus.m_we_i   = '0;
      bus.m_lock_i = '0;
      bus.m_sel_i  = '0;
      bus.m_adr_i  = '0;
      bus.m_dat_i  = '0;
      bus.s_dat_i  = 32'hDEAD_BEEF;
      bus.s_ack_i  = 1'b0;
      bus.s_err_i  = 1'b0;
      bus.s_rty_i  = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      if (bus.grant_o !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b want=00", bus.grant_o); end total++;
      if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin bad++; $display("FAIL rst_cyc_stb got=%b%b want=00", bus.s_cyc_o, bus.s_stb_o); end total++;
      if (bus.s_adr_o !== 32'h0 || bus.s_dat_o !== 32'h0) begin bad++; $display("FAIL rst_adr_dat got=%h/%h want=0/0", bus.s_adr_o, bus.s_dat_o); end total++;
      if ({bus.m_ack_o, bus.m_err_o, bus.m_rty_o, bus.timeout_o} !== 7'b0) begin bad++; $display("FAIL rst_term got=%b want=0", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o, bus.timeout_o}); end total++;
      if (bus.m_dat_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rst_mdat got=%h want=deadbeef", bus.m_dat_o); end total++;
      rst = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      drive_m(0, 1'b1, 1'b1, 1'b1, 1'b0, ADR_BAUD, 32'h0096_FEB5, 4'hF);
      #1;
      if (bus.s_cyc_o !== 1'b0) begin bad++; $display("FAIL single_latency got=%b want=0", bus.s_cyc_o); end total++;
      @(negedge clk); #1;
      if (bus.grant_o !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", bus.grant_o); end total++;
      if (bus.s_cyc_o !== 1'b1 || bus.s_we_o !== 1'b1) begin bad++; $display("FAIL single_cyc_we got=%b%b want=11", bus.s_cyc_o, bus.s_we_o); end total++;
      if (bus.s_adr_o !== 32'h4) begin bad++; $display("FAIL single_adr got=%h want=4", bus.s_adr_o); end total++;
      if (bus.s_dat_o !== 32'h0096_FEB5 || bus.s_sel_o !== 4'hF) begin bad++; $display("FAIL single_dat_sel got=%h/%h want=0096feb5/f", bus.s_dat_o, bus.s_sel_o); end total++;
      if (bus.m_ack_o !== 2'b00) begin bad++; $display("FAIL single_noack got=%b want=00", bus.m_ack_o); end total++;
      @(negedge clk);
      bus.s_ack_i = 1'b1;
      #1;
      if (bus.m_ack_o !== 2'b01) begin bad++; $display("FAIL single_ack got=%b want=01", bus.m_ack_o); end total++;
      @(negedge clk);
      bus.s_ack_i = 1'b0;
      drive_m(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk); #1;
      if (bus.grant_o !== 2'b00) begin bad++; $display("FAIL single_release got=%b want=00", bus.grant_o); end total++;
   endtask

   task automatic test_contention();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive_m(0, 1'b1, 1'b1, 1'b0, 1'b0, ADR_UART_CTRL, 32'h0, 4'hF);
      drive_m(1, 1'b1, 1'b1, 1'b0, 1'b0, ADR_UART_STAT, 32'h0, 4'hF);
      @(negedge clk);
      bus.s_ack_i = 1'b1;
      #1;
      if (bus.grant_o !== 2'b01) begin bad++; $display("FAIL cont_first got=%b want=01", bus.grant_o); end total++;
      if (bus.s_adr_o !== 32'h3) begin bad++; $display("FAIL cont_adr0 got=%h want=3", bus.s_adr_o); end total++;
      if (bus.m_ack_o !== 2'b01) begin bad++; $display("FAIL cont_ack0 got=%b want=01", bus.m_ack_o); end total++;
      @(negedge clk);
      bus.s_ack_i = 1'b0;
      drive_m(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk); #1;
      if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin bad++; $display("FAIL cont_dead got=%b/%b want=00/0", bus.grant_o, bus.s_cyc_o); end total++;
      @(negedge clk);
      bus.s_ack_i = 1'b1;
      #1;
      if (bus.grant_o !== 2'b10) begin bad++; $display("FAIL cont_second got=%b want=10", bus.grant_o); end total++;
      if (bus.s_adr_o !== 32'h5) begin bad++; $display("FAIL cont_adr1 got=%h want=5", bus.s_adr_o); end total++;
      if (bus.m_ack_o !== 2'b10) begin bad++; $display("FAIL cont_ack1 got=%b want=10", bus.m_ack_o); end total++;
      @(negedge clk);
      bus.s_ack_i = 1'b0;
      drive_m(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      drive_m(0, 1'b1, 1'b1, 1'b0, 1'b0, ADR_UART_CTRL, 32'h0, 4'hF);
      drive_m(1, 1'b1, 1'b1, 1'b0, 1'b0, ADR_UART_STAT, 32'h0, 4'hF);
      @(negedge clk); #1;
      if (bus.grant_o !== 2'b01) begin bad++; $display("FAIL cont_rr_back got=%b want=01", bus.grant_o); end total++;
      clear_all();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_lock();
      drive_m(1, 1'b1, 1'b1, 1'b0, 1'b1, ADR_CNT_CTRL, 32'h0, 4'hF);
      drive_m(0, 1'b1, 1'b1, 1'b0, 1'b0, ADR_RESULT, 32'h0, 4'hF);
      @(negedge clk);
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = 32'h0000_1234;
      #1;
      if (bus.grant_o !== 2'b10) begin bad++; $display("FAIL lock_grant got=%b want=10", bus.grant_o); end total++;
      if (bus.s_adr_o !== 32'h8 || bus.s_we_o !== 1'b0 || bus.s_lock_o !== 1'b1) begin bad++; $display("FAIL lock_read got=%h/%b/%b want=8/0/1", bus.s_adr_o, bus.s_we_o, bus.s_lock_o); end total++;
      if (bus.m_ack_o !== 2'b10 || bus.m_dat_o !== 32'h0000_1234) begin bad++; $display("FAIL lock_rdata got=%b/%h want=10/1234", bus.m_ack_o, bus.m_dat_o); end total++;
      @(negedge clk);
      bus.s_ack_i = 1'b0;
      drive_m(1, 1'b0, 1'b0, 1'b0, 1'b1, ADR_CNT_CTRL, 32'h0, 4'hF);
      #1;
      if (bus.s_cyc_o !== 1'b0) begin bad++; $display("FAIL lock_gap_cyc got=%b want=0", bus.s_cyc_o); end total++;
      @(negedge clk); #1;
      if (bus.grant_o !== 2'b10) begin bad++; $display("FAIL lock_gap_hold got=%b want=10", bus.grant_o); end total++;
      drive_m(1, 1'b1, 1'b1, 1'b1, 1'b1, ADR_CNT_CTRL, 32'h0000_00A5, 4'hF);
      bus.s_ack_i = 1'b1;
      #1;
      if (bus.s_we_o !== 1'b1 || bus.s_dat_o !== 32'hA5) begin bad++; $display("FAIL lock_write got=%b/%h want=1/a5", bus.s_we_o, bus.s_dat_o); end total++;
      if (bus.m_ack_o !== 2'b10) begin bad++; $display("FAIL lock_m0_noack got=%b want=10", bus.m_ack_o); end total++;
      @(negedge clk);
      bus.s_ack_i = 1'b0;
      drive_m(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk); #1;
      if (bus.grant_o !== 2'b00) begin bad++; $display("FAIL lock_release got=%b want=00", bus.grant_o); end total++;
      @(negedge clk); #1;
      if (bus.grant_o !== 2'b01 || bus.s_adr_o !== 32'h9) begin bad++; $display("FAIL lock_m0_after got=%b/%h want=01/9", bus.grant_o, bus.s_adr_o); end total++;
      clear_all();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int k;
      drive_m(0, 1'b1, 1'b1, 1'b0, 1'b0, ADR_RESULT, 32'h0, 4'hF);
      @(negedge clk); #1;
      if (bus.s_stb_o !== 1'b1) begin bad++; $display("FAIL to_first_stb got=%b want=1", bus.s_stb_o); end total++;
      k = 0;
      while (bus.timeout_o !== 1'b1 && k < 40) begin
         @(negedge clk); #1;
         k++;
      end
      if (k != 16) begin bad++; $display("FAIL to_latency got=%0d want=16", k); end total++;
      if (bus.m_err_o !== 2'b01) begin bad++; $display("FAIL to_err got=%b want=01", bus.m_err_o); end total++;
      if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin bad++; $display("FAIL to_cut got=%b%b want=00", bus.s_cyc_o, bus.s_stb_o); end total++;
      if (bus.grant_o !== 2'b01) begin bad++; $display("FAIL to_keep_grant got=%b want=01", bus.grant_o); end total++;
      @(negedge clk); #1;
      if (bus.timeout_o !== 1'b0 || bus.m_err_o !== 2'b00 || bus.s_cyc_o !== 1'b1) begin bad++; $display("FAIL to_pulse_end got=%b/%b/%b want=0/00/1", bus.timeout_o, bus.m_err_o, bus.s_cyc_o); end total++;
      clear_all();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_err_ack();
      drive_m(0, 1'b1, 1'b1, 1'b1, 1'b0, ADR_TX_BUF, 32'h41, 4'h1);
      @(negedge clk);
      bus.s_ack_i = 1'b1;
      bus.s_err_i = 1'b1;
      #1;
      if (bus.m_err_o !== 2'b01) begin bad++; $display("FAIL errack_err got=%b want=01", bus.m_err_o); end total++;
      if (bus.m_ack_o !== 2'b00) begin bad++; $display("FAIL errack_ack got=%b want=00", bus.m_ack_o); end total++;
      @(negedge clk);
      clear_all();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      drive_m(1, 1'b1, 1'b1, 1'b1, 1'b0, ADR_INTERP, 32'h55, 4'hF);
      @(negedge clk); #1;
      if (bus.grant_o !== 2'b10) begin bad++; $display("FAIL rmid_own got=%b want=10", bus.grant_o); end total++;
      rst = 1'b1;
      drive_m(0, 1'b1, 1'b1, 1'b0, 1'b0, ADR_UART_CTRL, 32'h0, 4'hF);
      @(negedge clk);
      bus.s_ack_i = 1'b1;
      #1;
      if (bus.grant_o !== 2'b00) begin bad++; $display("FAIL rmid_grant got=%b want=00", bus.grant_o); end total++;
      if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.s_adr_o !== 32'h0) begin bad++; $display("FAIL rmid_slave got=%b%b/%h want=00/0", bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o); end total++;
      if (bus.m_ack_o !== 2'b00 || bus.m_err_o !== 2'b00) begin bad++; $display("FAIL rmid_noterm got=%b/%b want=00/00", bus.m_ack_o, bus.m_err_o); end total++;
      rst = 1'b0;
      bus.s_ack_i = 1'b0;
      @(negedge clk); #1;
      if (bus.grant_o !== 2'b01 || bus.s_adr_o !== 32'h3) begin bad++; $display("FAIL rmid_m0_first got=%b/%h want=01/3", bus.grant_o, bus.s_adr_o); end total++;
      clear_all();
      @(negedge clk);
   endtask

   initial begin
      clear_all();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_single();
      test_contention();
      test_lock();
      test_timeout();
      test_err_ack();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before the test sequence finished");
      $fatal(1);
   end

endmodule
